// File: rtl/nios_cpu_nios2_qsys_0_oci_dct_gen.sv
// OCI debug-control-trace producer: packs 2-bit trace symbols into a 15-symbol
// buffer and hands completed or flushed buffers to the trace RAM as 36-bit words.
module nios_cpu_nios2_qsys_0_oci_dct_gen (
    input  logic        clk,
    input  logic        reset,
    input  logic        sym_valid,
    input  logic [1:0]  sym,
    output logic        sym_ready,
    input  logic        flush,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count,
    output logic        tw_valid,
    output logic [35:0] tw_data,
    input  logic        tw_ready
);

    typedef enum logic {
        FILL,
        STALL
    } state_t;

    state_t      state;
    logic [29:0] shift_q;
    logic [3:0]  count_q;
    logic        flush_pend_q;
    logic        tw_valid_q;
    logic [35:0] tw_data_q;

    logic        acc;
    logic        out_free;
    logic        emit;
    logic [29:0] buf_n;
    logic [3:0]  cnt_n;
    logic [29:0] shift_d;
    logic [3:0]  count_d;
    logic        flush_pend_d;
    logic        tw_valid_d;
    logic [35:0] tw_data_d;

    // The buffer count is the state: a full buffer means the output register
    // could not take it yet, so symbols are refused until it drains.
    always_comb begin
        state = FILL;
        if (count_q == 4'd15) begin
            state = STALL;
        end
    end

    assign sym_ready = (state == FILL);

    always_comb begin
        acc      = sym_valid && sym_ready;
        out_free = !tw_valid_q || tw_ready;
        buf_n    = acc ? {shift_q[27:0], sym} : shift_q;
        cnt_n    = count_q + {3'b000, acc};
        emit     = out_free &&
                   ((cnt_n == 4'd15) || ((flush || flush_pend_q) && (cnt_n != 4'd0)));

        shift_d      = buf_n;
        count_d      = cnt_n;
        flush_pend_d = flush_pend_q || (flush && (cnt_n != 4'd0));
        tw_valid_d   = tw_valid_q && !tw_ready;
        tw_data_d    = tw_data_q;

        // Emitting takes the buffer including this cycle's symbol, so a
        // simultaneous symbol and flush land in the same word.
        if (emit) begin
            shift_d      = '0;
            count_d      = '0;
            flush_pend_d = 1'b0;
            tw_valid_d   = 1'b1;
            tw_data_d    = {cnt_n, 2'b00, buf_n};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q      <= '0;
            count_q      <= '0;
            flush_pend_q <= 1'b0;
            tw_valid_q   <= 1'b0;
            tw_data_q    <= '0;
        end else begin
            shift_q      <= shift_d;
            count_q      <= count_d;
            flush_pend_q <= flush_pend_d;
            tw_valid_q   <= tw_valid_d;
            tw_data_q    <= tw_data_d;
        end
    end

    assign dct_buffer = shift_q;
    assign dct_count  = count_q;
    assign tw_valid   = tw_valid_q;
    assign tw_data    = tw_data_q;

endmodule

// File: doc/nios_cpu_nios2_qsys_0_oci_dct_gen.md
# nios_cpu_nios2_qsys_0_oci_dct_gen

Producer side of the OCI debug-control-trace (DCT) path. It takes 2-bit trace symbols from the OCI trace logic and packs them into the 30-bit `dct_buffer` / 4-bit `dct_count` pair that the OCI test bench monitors. It also emits each completed or flushed buffer as a 36-bit trace word over a valid/ready handshake to the trace memory. It sits between the OCI trace encoder and the on-chip trace RAM writer.

## Interface
Parameters:
- None. Widths are fixed: 15 symbols × 2 bits = 30-bit buffer; 36-bit output word.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `sym_valid`  in  1  trace symbol present.
- `sym`  in  2  trace symbol code.
- `sym_ready`  out  1  block can accept a symbol this cycle.
- `flush`  in  1  single-cycle request to emit the partial buffer.
- `dct_buffer`  out  30  packed symbols; the newest symbol is in [1:0].
- `dct_count`  out  4  number of valid symbols in `dct_buffer` (0..15).
- `tw_valid`  out  1  trace word valid.
- `tw_data`  out  36  `{dct_count_at_emit[3:0], 2'b00, dct_buffer_at_emit[29:0]}`.
- `tw_ready`  in  1  trace memory accepts the word.

## Operation
- Accept: `acc = sym_valid && sym_ready`. On `acc`, `buf <= {buf[27:0], sym}` and `count <= count + 1`.
- `out_free = !tw_valid || tw_ready`.
- Next-state values: `cnt_n = count + acc`, `buf_n` = buffer after any shift.
- Emit condition: `emit = out_free && ((cnt_n == 15) || ((flush || flush_pend) && cnt_n != 0))`.
- On `emit`:
  - `tw_data <= {cnt_n, 2'b00, buf_n}`.
  - `tw_valid <= 1`.
  - `buf <= 0`, `count <= 0`, `flush_pend <= 0`.
- If `tw_ready && tw_valid && !emit`, then `tw_valid <= 0`.
- `tw_data` is held stable while `tw_valid && !tw_ready`.
- Flush handling:
  - Flush while `!out_free` with `cnt_n != 0`: set `flush_pend`; emit on the first cycle `out_free` holds.
  - Flush with `cnt_n == 0`: no word, no pending flag.
  - Additional flushes while `flush_pend` is set merge into it.
- State machine, derived from `count` and `tw_valid`:
  - FILL: `count < 15`.
  - STALL: `count == 15`, output register busy. `sym_ready = 0`. Exit to FILL on `out_free`, which emits the held buffer.
- `sym_ready = (count != 15)`. This is a combinational function of registered state only, with no path from `tw_ready`.
- Symbols are never dropped or duplicated. Word order equals symbol order.
- `dct_buffer` and `dct_count` are direct register outputs of `buf` and `count`.
- Unused upper bits of `buf` are zero when `count < 15`. The buffer is right-aligned.

## Timing
- Reset values: `dct_buffer = 0`, `dct_count = 0`, `tw_valid = 0`, `tw_data = 0`, `flush_pend = 0`, `sym_ready = 1`.
- Reset mid-operation discards the partial buffer and any valid-but-unaccepted word. Reset has priority over every other input.
- Latency:
  - `dct_count` and `dct_buffer` reflect an accepted symbol 1 cycle after acceptance.
  - With the output free, `tw_valid` rises 1 cycle after the 15th symbol is accepted or after `flush`. The count never reads 15 in that case.
- Sustained throughput: 1 symbol/cycle. With `tw_ready` tied high this is lossless indefinitely: one word per 15 symbols and no stall.
- Simultaneous events:
  - Symbol and flush in the same cycle: the symbol is included in the flushed word.
  - Emit and `tw_ready` in the same cycle: the old word retires and the new one loads; `tw_valid` stays 1.
- Wrap-around: the count never exceeds 15. The 15→0 transition happens only through emit.

## Test plan
- Reset, then 15 symbols of `2'b01` back-to-back with `tw_ready = 1` → `tw_valid` high 1 cycle after the 15th; `tw_data = 36'hF_1555_5555`; `dct_count` back to 0; `sym_ready` never low.
- 3 symbols `2'b11, 2'b10, 2'b01`, then `flush` → `tw_data = {4'd3, 2'b00, 30'h39}`; an immediate second `flush` produces no word.
- `tw_ready = 0`, 30 symbols offered → first word held stable; `dct_count` reaches 15 and `sym_ready` drops; on `tw_ready = 1` the second word follows with no lost symbols; check 30 symbols in order across both words.
- Flush while the output is busy (`count = 4`) → `flush_pend` set; word with count 4 emitted the cycle after `tw_ready` retires the prior word.
- Symbol and `flush` in the same cycle at `count = 14` → single word with count 15, no extra empty word.
- Assert `reset` at `count = 9` with `tw_valid` high → next cycle all outputs are 0 and `sym_ready = 1`; no stale word appears afterwards.
